sdp_nrdma_eg_ro_lane_sched: RTL and testbench
=============================================

Name: sdp_nrdma_eg_ro_lane_sched

Overview:
In-order lane scheduler for the SDP NRDMA egress reorder stage. It drains NUM_LANE single-entry reorder-output data FIFOs (one per lane, 256-bit payload) in strict round-robin lane order, as directed by a per-command descriptor. It merges the beats into one registered 256-bit stream toward the SDP datapath and marks the command-last beat and layer end.

Parameters:
NUM_LANE, 4, number of lane dfifos drained; lane index width LW = clog2(NUM_LANE)
PD_W, 256, payload width per beat
CNT_W, 13, beat counter width (max 8192 beats per command)

Ports:
nvdla_core_clk  in  1  core clock; the only clock
nvdla_core_rst  in  1  reset, synchronous, active-high
op_en  in  1  enables command acceptance
cmd_pvld  in  1  command valid
cmd_prdy  out  1  command ready
cmd_lane_num  in  LW  lanes used by this command, minus 1
cmd_beat_num  in  CNT_W  total beats in this command, minus 1
cmd_last  in  1  command is the last of the layer
rod_rd_pvld  in  NUM_LANE  per-lane dfifo output valid
rod_rd_prdy  out  NUM_LANE  per-lane dfifo pop ready
rod_rd_pd  in  NUM_LANE*PD_W  per-lane payload; lane i occupies bits [i*PD_W +: PD_W]
dp_pvld  out  1  output beat valid
dp_prdy  in  1  output beat ready
dp_pd  out  PD_W  output payload
dp_last  out  1  last beat of the command
layer_done  out  1  single-cycle pulse at layer end
busy  out  1  FSM is in RUN or the output register holds data

Behaviour:
- Reset: FSM=IDLE, lane_ptr=0, beat_cnt=0, dp_pvld=0, dp_last=0, dp_pd=0, layer_done=0, cmd_prdy=0 during reset, rod_rd_prdy=0, busy=0. Reset takes effect on the clock edge only. Reset mid-command drops all state, including a held output beat.
- FSM has two states, IDLE and RUN.
- IDLE:
  - cmd_prdy = op_en.
  - On cmd_pvld & cmd_prdy: latch lane_num, beat_num and cmd_last; lane_ptr=0; beat_cnt=0; go to RUN.
  - cmd_lane_num >= NUM_LANE is clamped to NUM_LANE-1.
- RUN:
  - cmd_prdy=0.
  - Output register accepts a beat when out_en = !dp_pvld | dp_prdy.
  - rod_rd_prdy[lane_ptr] = out_en; all other lanes get 0.
  - Valid on non-selected lanes is ignored, never popped.
- Beat accept = rod_rd_pvld[lane_ptr] & rod_rd_prdy[lane_ptr]. On accept:
  - dp_pd <= lane payload; dp_pvld <= 1; dp_last <= (beat_cnt == beat_num); internal lyr_end <= dp_last-term & cmd_last.
  - lane_ptr <= (lane_ptr == lane_num) ? 0 : lane_ptr+1. Wraps on lane_num, not NUM_LANE.
  - beat_cnt <= beat_cnt+1. If it was the final beat: beat_cnt=0, lane_ptr=0, go to IDLE.
- Output register is a 1-deep pipe stage:
  - Latency is 1 cycle from lane pop to dp_pvld.
  - With dp_prdy held high, full throughput of 1 beat/cycle.
  - dp_pd, dp_last and lyr_end are held stable while dp_pvld & !dp_prdy.
  - When dp_prdy & dp_pvld and no new accept: dp_pvld <= 0.
- layer_done pulses 1 cycle, in the cycle after a dp handshake whose beat carries lyr_end=1.
- There is one bubble between commands: a new command is accepted only in IDLE, at the earliest the cycle after the final beat accept. The output register may still hold the final beat while the next command is accepted.
- op_en gates only command acceptance. Deasserting it mid-command does not stop the current command.
- beat_num=0 gives a 1-beat command with dp_last=1 on that beat. lane_num=0 gives every beat from lane 0.
- Simultaneous events in the same cycle (dp handshake plus new lane accept) replace the register contents with no gap.
- busy = (state==RUN) | dp_pvld.

Decomposition:
- Shared package sdp_nrdma_eg_ro_pkg holds:
  - NUM_LANE, PD_W, CNT_W and derived LW
  - FSM state enum {IDLE, RUN}
  - command descriptor struct {lane_num, beat_num, last}
- One sub-module: sdp_nrdma_eg_ro_out_pipe, the 1-deep valid/ready register for {pd, last, lyr_end} that exports out_en.
- Lane mux and FSM stay in the top module.

Test Plan:
- Reset, then cmd lane_num=3, beat_num=7, cmd_last=0, all lanes valid, dp_prdy=1 -> 8 beats from lanes 0,1,2,3,0,1,2,3 on consecutive cycles; first dp_pvld 1 cycle after first pop; dp_last on beat 8 only; no layer_done.
- cmd lane_num=1, beat_num=4, cmd_last=1 -> lanes 0,1,0,1,0; layer_done pulses once, in the cycle after the 5th dp handshake.
- Same as test 1 but dp_prdy low for 3 cycles at beat 2 -> dp_pd/dp_last stable; no rod_rd_prdy asserted during the stall; no beat lost or duplicated.
- Lane 2 valid withheld for 5 cycles while lane_ptr=2, with lanes 0/1/3 valid -> rod_rd_prdy[0,1,3] stay 0; scheduler waits on lane 2; order is preserved.
- Two back-to-back cmds (beat_num=0, then beat_num=2), with op_en dropped after the 2nd cmd is accepted -> exactly 1 idle cycle between commands; 2nd command completes; cmd_prdy=0 afterwards.
- nvdla_core_rst asserted mid-command at beat 3 -> next edge: dp_pvld=0, busy=0, cmd_prdy=op_en after release; new cmd starts at lane 0.

Source files
------------

// File: rtl/sdp_nrdma_eg_ro_pkg.sv
// Shared definitions for the SDP NRDMA egress reorder lane scheduler.
// Holds the geometry constants, the scheduler FSM state type, the command
// descriptor layout and a helper that limits a lane count to what exists.
package sdp_nrdma_eg_ro_pkg;

  localparam int NUM_LANE = 4;    // lane dfifos drained by the scheduler
  localparam int PD_W     = 256;  // payload width per beat
  localparam int CNT_W    = 13;   // beat counter width (up to 8192 beats)
  localparam int LW       = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Latched copy of the command taken on the command handshake.
  typedef struct packed {
    logic [LW-1:0]    lane_num;  // lanes used, minus 1
    logic [CNT_W-1:0] beat_num;  // beats in the command, minus 1
    logic             last;      // command closes the layer
  } cmd_desc_t;

  // A lane count that names a lane beyond the last one is treated as
  // "use every lane".
  function automatic logic [LW-1:0] clamp_lane(input logic [LW-1:0] lane);
    if (int'(lane) >= NUM_LANE) return LW'(NUM_LANE - 1);
    return lane;
  endfunction

endpackage

// File: rtl/sdp_nrdma_eg_ro_out_pipe.sv
// One-deep valid/ready output register for the lane scheduler.
// Holds {pd, last, lyr_end} for one beat and raises a one-cycle layer-done
// pulse in the cycle after a beat marked lyr_end leaves the register.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   i_vld           load a new beat (only raised while o_en is high)
//   i_pd/i_last/i_lyr_end  beat contents
//   o_en            register can take a beat this cycle (empty or draining)
//   o_vld/i_rdy     output handshake
//   o_pd/o_last     registered beat
//   o_layer_done    pulse after the layer-ending beat is handed off
module sdp_nrdma_eg_ro_out_pipe
  import sdp_nrdma_eg_ro_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld,
  input  logic [PD_W-1:0] i_pd,
  input  logic            i_last,
  input  logic            i_lyr_end,
  output logic            o_en,
  output logic            o_vld,
  input  logic            i_rdy,
  output logic [PD_W-1:0] o_pd,
  output logic            o_last,
  output logic            o_layer_done
);

  logic            r_vld;
  logic [PD_W-1:0] r_pd;
  logic            r_last;
  logic            r_lyr_end;
  logic            r_layer_done;

  // A draining beat and a new load in the same cycle swap contents with no gap.
  assign o_en = !r_vld | i_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld        <= 1'b0;
      r_pd         <= '0;
      r_last       <= 1'b0;
      r_lyr_end    <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= r_vld & i_rdy & r_lyr_end;
      if (i_vld) begin
        r_vld     <= 1'b1;
        r_pd      <= i_pd;
        r_last    <= i_last;
        r_lyr_end <= i_lyr_end;
      end else if (i_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld        = r_vld;
  assign o_pd         = r_pd;
  assign o_last       = r_last;
  assign o_layer_done = r_layer_done;

endmodule

// File: rtl/sdp_nrdma_eg_ro_lane_sched.sv
// In-order lane scheduler for the SDP NRDMA egress reorder stage.
// Drains NUM_LANE single-entry lane dfifos in round-robin order (lanes
// 0..lane_num, repeating) for beat_num+1 beats per command, and merges the
// beats into one registered stream with command-last and layer-end marks.
//
// Handshakes: every interface transfers on the rising edge where its valid
// and ready are both high; valid never waits on ready, and a held beat keeps
// its contents until it transfers.
//
// Ports:
//   nvdla_core_clk/nvdla_core_rst  clock, synchronous active-high reset
//   op_en                          gates command acceptance only
//   cmd_pvld/cmd_prdy              command handshake (ready only in IDLE)
//   cmd_lane_num/beat_num/last     command descriptor
//   rod_rd_pvld/prdy/pd            per-lane dfifo pop interface
//   dp_pvld/prdy/pd/last           merged output stream
//   layer_done                     one-cycle pulse after the layer's final beat
//   busy                           command running or output beat pending
//   dbg_state                      current FSM state (0=IDLE, 1=RUN)
module sdp_nrdma_eg_ro_lane_sched
  import sdp_nrdma_eg_ro_pkg::*;
(
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  input  logic                     op_en,
  input  logic                     cmd_pvld,
  output logic                     cmd_prdy,
  input  logic [LW-1:0]            cmd_lane_num,
  input  logic [CNT_W-1:0]         cmd_beat_num,
  input  logic                     cmd_last,
  input  logic [NUM_LANE-1:0]      rod_rd_pvld,
  output logic [NUM_LANE-1:0]      rod_rd_prdy,
  input  logic [NUM_LANE*PD_W-1:0] rod_rd_pd,
  output logic                     dp_pvld,
  input  logic                     dp_prdy,
  output logic [PD_W-1:0]          dp_pd,
  output logic                     dp_last,
  output logic                     layer_done,
  output logic                     busy,
  output logic                     dbg_state
);

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_desc_t        r_cmd;
  logic [LW-1:0]    r_lane_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_out_en;
  logic             w_cmd_acc;
  logic             w_beat_acc;
  logic             w_final;
  logic [PD_W-1:0]  w_sel_pd;

  assign w_final  = (r_beat_cnt == r_cmd.beat_num);
  assign w_sel_pd = rod_rd_pd[r_lane_ptr*PD_W +: PD_W];

  // Readies are held low while reset is asserted so nothing is popped or
  // accepted on the reset edge.
  always_comb begin
    w_state_nxt = r_state;
    cmd_prdy    = 1'b0;
    rod_rd_prdy = '0;
    w_cmd_acc   = 1'b0;
    w_beat_acc  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_prdy  = op_en & !nvdla_core_rst;
        w_cmd_acc = cmd_pvld & cmd_prdy;
        if (w_cmd_acc) w_state_nxt = RUN;
      end
      RUN: begin
        // Only the lane under the pointer may pop; valids elsewhere wait.
        rod_rd_prdy[r_lane_ptr] = w_out_en & !nvdla_core_rst;
        w_beat_acc = rod_rd_pvld[r_lane_ptr] & rod_rd_prdy[r_lane_ptr];
        if (w_beat_acc && w_final) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_lane_ptr <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_acc) begin
        r_cmd.lane_num <= clamp_lane(cmd_lane_num);
        r_cmd.beat_num <= cmd_beat_num;
        r_cmd.last     <= cmd_last;
        r_lane_ptr     <= '0;
        r_beat_cnt     <= '0;
      end else if (w_beat_acc) begin
        if (w_final) begin
          r_lane_ptr <= '0;
          r_beat_cnt <= '0;
        end else begin
          // Wrap on the command's lane count, not on the physical lane count.
          r_lane_ptr <= (r_lane_ptr == r_cmd.lane_num) ? '0 : r_lane_ptr + 1'b1;
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  sdp_nrdma_eg_ro_out_pipe u_out_pipe (
    .clk          (nvdla_core_clk),
    .rst          (nvdla_core_rst),
    .i_vld        (w_beat_acc),
    .i_pd         (w_sel_pd),
    .i_last       (w_final),
    .i_lyr_end    (w_final & r_cmd.last),
    .o_en         (w_out_en),
    .o_vld        (dp_pvld),
    .i_rdy        (dp_prdy),
    .o_pd         (dp_pd),
    .o_last       (dp_last),
    .o_layer_done (layer_done)
  );

  assign busy      = (r_state == RUN) | dp_pvld;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sdp_nrdma_eg_ro_lane_sched.sv
module tb_sdp_nrdma_eg_ro_lane_sched;
  import sdp_nrdma_eg_ro_pkg::*;

  // ---------------- clock / reset / DUT signals ----------------
  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     op_en = 1'b0;
  logic                     cmd_pvld = 1'b0;
  logic                     cmd_prdy;
  logic [LW-1:0]            cmd_lane_num = '0;
  logic [CNT_W-1:0]         cmd_beat_num = '0;
  logic                     cmd_last = 1'b0;
  logic [NUM_LANE-1:0]      rod_rd_pvld;
  logic [NUM_LANE-1:0]      rod_rd_prdy;
  logic [NUM_LANE*PD_W-1:0] rod_rd_pd;
  logic                     dp_pvld;
  logic                     dp_prdy = 1'b0;
  logic [PD_W-1:0]          dp_pd;
  logic                     dp_last;
  logic                     layer_done;
  logic                     busy;
  logic                     dbg_state;

  always #5 clk = ~clk;

  sdp_nrdma_eg_ro_lane_sched dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .op_en          (op_en),
    .cmd_pvld       (cmd_pvld),
    .cmd_prdy       (cmd_prdy),
    .cmd_lane_num   (cmd_lane_num),
    .cmd_beat_num   (cmd_beat_num),
    .cmd_last       (cmd_last),
    .rod_rd_pvld    (rod_rd_pvld),
    .rod_rd_prdy    (rod_rd_prdy),
    .rod_rd_pd      (rod_rd_pd),
    .dp_pvld        (dp_pvld),
    .dp_prdy        (dp_prdy),
    .dp_pd          (dp_pd),
    .dp_last        (dp_last),
    .layer_done     (layer_done),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [PD_W+1:0] exp_q[$];      // {lyr_end, last, pd}
  int              hs_cyc_log[$];
  int              hs_cnt = 0;
  int              ld_cnt = 0;
  logic            exp_ld = 1'b0;
  logic            mon_ld;
  logic [PD_W+1:0] mon_e;

  int                  lane_cnt[NUM_LANE];
  int                  exp_cnt[NUM_LANE];
  logic [NUM_LANE-1:0] lane_mask = '1;
  logic [NUM_LANE-1:0] snap;

  function automatic logic [PD_W-1:0] make_pd(input int lane, input int n);
    logic [31:0] w;
    w = {8'(lane + 1), 8'hC3, 16'(n)};
    return {8{w}};
  endfunction

  task automatic check_wide(input string name, input logic [PD_W:0] act, input logic [PD_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- lane dfifo model ----------------
  assign rod_rd_pvld = lane_mask;

  always_comb begin
    rod_rd_pd = '0;
    for (int i = 0; i < NUM_LANE; i++) rod_rd_pd[i*PD_W +: PD_W] = make_pd(i, lane_cnt[i]);
  end

  always begin
    @(negedge clk);
    snap = rod_rd_pvld & rod_rd_prdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_LANE; i++) if (snap[i]) lane_cnt[i]++;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_ld = 1'b0;
    end else begin
      check_int("layer_done", int'(layer_done), int'(exp_ld));
      if (layer_done) ld_cnt++;
      mon_ld = 1'b0;
      if (dp_pvld && dp_prdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dp_beat: got unexpected beat %h expected none", dp_pd);
        end else begin
          mon_e = exp_q.pop_front();
          check_wide("dp_beat", {dp_last, dp_pd}, mon_e[PD_W:0]);
          mon_ld = mon_e[PD_W+1];
        end
        hs_cnt++;
        hs_cyc_log.push_back(cyc);
      end
      exp_ld = mon_ld;
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic send_cmd(input int lanes, input int beats, input logic lst, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    cmd_pvld     = 1'b1;
    cmd_lane_num = LW'(lanes);
    cmd_beat_num = CNT_W'(beats);
    cmd_last     = lst;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (cmd_prdy) begin
        got = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    cmd_pvld = 1'b0;
    check_int("cmd_accept", int'(got), 1);
    if (got) begin
      for (int k = 0; k <= beats; k++) begin
        int ln;
        ln = k % (lanes + 1);
        exp_q.push_back({lst && (k == beats), (k == beats), make_pd(ln, exp_cnt[ln])});
        exp_cnt[ln]++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_int({name, "_drained"}, int'(done), 1);
  endtask

  task automatic wait_hs(input int n);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      #1;
      if (hs_cnt >= n) done = 1'b1;
    end
    @(posedge clk);
    #1;
    check_int("wait_handshake", int'(done), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int a0, a1, h0, l0;
    op_en   = 1'b1;
    rst     = 1'b1;
    dp_prdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_int("rst_cmd_prdy", int'(cmd_prdy), 0);
    check_int("rst_rod_prdy", int'(rod_rd_prdy), 0);
    check_int("rst_dp_pvld", int'(dp_pvld), 0);
    check_int("rst_dp_last", int'(dp_last), 0);
    check_wide("rst_dp_pd", {1'b0, dp_pd}, '0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_state", int'(dbg_state), 0);
    check_int("rst_layer_done", int'(layer_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("idle_cmd_prdy", int'(cmd_prdy), 1);
    @(posedge clk);
    #1;

    // T1: 4 lanes, 8 beats, full throughput
    h0 = hs_cnt; l0 = ld_cnt;
    send_cmd(3, 7, 1'b0, a0);
    wait_drain("t1");
    check_int("t1_beats", hs_cnt - h0, 8);
    check_int("t1_first_latency", hs_cyc_log[h0] - a0, 2);
    check_int("t1_burst_span", hs_cyc_log[h0+7] - hs_cyc_log[h0], 7);
    check_int("t1_layer_done_cnt", ld_cnt - l0, 0);

    // T2: 2 lanes, 5 beats, layer end
    h0 = hs_cnt; l0 = ld_cnt;
    send_cmd(1, 4, 1'b1, a0);
    wait_drain("t2");
    repeat (2) @(posedge clk);
    #1;
    check_int("t2_beats", hs_cnt - h0, 5);
    check_int("t2_layer_done_cnt", ld_cnt - l0, 1);

    // T3: output stall of 3 cycles holding beat 2
    h0 = hs_cnt;
    send_cmd(3, 7, 1'b0, a0);
    wait_hs(h0 + 1);
    dp_prdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_int("t3_stall_pvld", int'(dp_pvld), 1);
      check_int("t3_stall_rod_prdy", int'(rod_rd_prdy), 0);
      if (exp_q.size() > 0) check_wide("t3_stall_hold", {dp_last, dp_pd}, exp_q[0][PD_W:0]);
      @(posedge clk);
      #1;
    end
    dp_prdy = 1'b1;
    wait_drain("t3");
    check_int("t3_beats", hs_cnt - h0, 8);

    // T4: lane 2 withheld while the pointer sits on it
    h0 = hs_cnt;
    lane_mask = 4'b1011;
    send_cmd(3, 7, 1'b0, a0);
    repeat (2) @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check_int("t4_rod_prdy", int'(rod_rd_prdy), 4);
      @(posedge clk);
      #1;
    end
    lane_mask = '1;
    wait_drain("t4");
    check_int("t4_beats", hs_cnt - h0, 8);

    // T5: back-to-back commands, op_en dropped after the second
    h0 = hs_cnt;
    send_cmd(0, 0, 1'b0, a0);
    send_cmd(2, 2, 1'b0, a1);
    op_en = 1'b0;
    check_int("t5_cmd_gap", a1 - a0, 2);
    wait_drain("t5");
    check_int("t5_beats", hs_cnt - h0, 4);
    @(negedge clk);
    check_int("t5_cmd_prdy_off", int'(cmd_prdy), 0);
    @(posedge clk);
    #1;
    op_en = 1'b1;

    // T6: reset in the middle of a command
    h0 = hs_cnt;
    send_cmd(3, 7, 1'b0, a0);
    wait_hs(h0 + 3);
    rst = 1'b1;
    dp_prdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("t6_dp_pvld", int'(dp_pvld), 0);
    check_int("t6_busy", int'(busy), 0);
    check_int("t6_state", int'(dbg_state), 0);
    check_int("t6_cmd_prdy_rst", int'(cmd_prdy), 0);
    check_int("t6_rod_prdy", int'(rod_rd_prdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dp_prdy = 1'b1;
    #1;
    exp_q.delete();
    for (int i = 0; i < NUM_LANE; i++) exp_cnt[i] = lane_cnt[i];
    @(negedge clk);
    check_int("t6_cmd_prdy_rel", int'(cmd_prdy), 1);
    @(posedge clk);
    #1;
    h0 = hs_cnt;
    send_cmd(1, 3, 1'b0, a0);
    wait_drain("t6");
    check_int("t6_beats", hs_cnt - h0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
